// File: rtl/lif_pkg.sv
// Shared types and widths for the time-multiplexed LIF neuron array.
package lif_pkg;

   localparam int V_W = 8;
   localparam int R_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_UPDATE = 3'd2,
      ST_EMIT   = 3'd3,
      ST_DONE   = 3'd4
   } lif_sched_state_t;

endpackage

// File: rtl/lif_update_core.sv
// Combinational leaky-integrate-fire update for one neuron: refractory countdown,
// fire-on-stored-threshold, leak-and-integrate with saturation at the threshold.
module lif_update_core
   import lif_pkg::*;
#(
   parameter logic [V_W-1:0] THRESHOLD     = 8'd255,
   parameter logic [V_W-1:0] LEAK_RATE     = 8'd1,
   parameter int             REFRAC_PERIOD = 32
) (
   input  logic [V_W-1:0] v,
   input  logic [R_W-1:0] r,
   input  logic [V_W-1:0] i_cur,
   output logic [V_W-1:0] v_next,
   output logic [R_W-1:0] r_next,
   output logic           spike
);

   logic [V_W:0] sum;

   always_comb begin
      // Only consumed when v >= LEAK_RATE, so the subtraction never wraps where it matters.
      sum    = {1'b0, v} + {1'b0, i_cur} - {1'b0, LEAK_RATE};
      v_next = v;
      r_next = r;
      spike  = 1'b0;
      if (r != '0) begin
         r_next = r - R_W'(1);
      end else if (v >= THRESHOLD) begin
         v_next = '0;
         r_next = R_W'(REFRAC_PERIOD);
         spike  = 1'b1;
      end else if (v < LEAK_RATE) begin
         v_next = i_cur;
      end else if (sum[V_W]) begin
         v_next = THRESHOLD;
      end else begin
         v_next = sum[V_W-1:0];
      end
   end

endmodule

// File: rtl/lif_array_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update core per tick,
// streaming spiking neuron indices out as address-events.
//
// state  | meaning
// IDLE   | waiting for tick
// READ   | cur_rd asserted for neuron idx
// UPDATE | cur_data valid; neuron idx updated
// EMIT   | spike event for idx held until spike_ready
// DONE   | done pulse; spike_count latched
module lif_array_scheduler
   import lif_pkg::*;
#(
   parameter int          NUM_NEURONS   = 16,
   parameter logic [7:0]  THRESHOLD     = 8'd255,
   parameter logic [7:0]  LEAK_RATE     = 8'd1,
   parameter int          REFRAC_PERIOD = 32,
   parameter int          AW            = $clog2(NUM_NEURONS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   output logic          busy,
   output logic          done,
   output logic          overrun,
   output logic          cur_rd,
   output logic [AW-1:0] cur_addr,
   input  logic [7:0]    cur_data,
   output logic          spike_valid,
   output logic [AW-1:0] spike_addr,
   input  logic          spike_ready,
   output logic [AW:0]   spike_count
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

   lif_sched_state_t state;
   logic [AW-1:0]    idx;
   logic [AW:0]      run_cnt;
   logic [V_W-1:0]   v_mem [NUM_NEURONS];
   logic [R_W-1:0]   r_mem [NUM_NEURONS];

   logic [V_W-1:0]   v_next;
   logic [R_W-1:0]   r_next;
   logic             spike;
   logic             last;

   assign last = (idx == LAST_IDX);

   lif_update_core #(
      .THRESHOLD     (THRESHOLD),
      .LEAK_RATE     (LEAK_RATE),
      .REFRAC_PERIOD (REFRAC_PERIOD)
   ) u_core (
      .v      (v_mem[idx]),
      .r      (r_mem[idx]),
      .i_cur  (cur_data),
      .v_next (v_next),
      .r_next (r_next),
      .spike  (spike)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         run_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         cur_rd      <= 1'b0;
         cur_addr    <= '0;
         spike_valid <= 1'b0;
         spike_addr  <= '0;
         spike_count <= '0;
         for (int k = 0; k < NUM_NEURONS; k++) begin
            v_mem[k] <= '0;
            r_mem[k] <= '0;
         end
      end else begin
         done    <= 1'b0;
         cur_rd  <= 1'b0;
         overrun <= tick && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  idx      <= '0;
                  run_cnt  <= '0;
                  busy     <= 1'b1;
                  cur_rd   <= 1'b1;
                  cur_addr <= '0;
                  state    <= ST_READ;
               end
            end
            ST_READ: begin
               state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               v_mem[idx] <= v_next;
               r_mem[idx] <= r_next;
               if (spike) begin
                  spike_valid <= 1'b1;
                  spike_addr  <= idx;
                  state       <= ST_EMIT;
               end else if (last) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx      <= idx + AW'(1);
                  cur_addr <= idx + AW'(1);
                  cur_rd   <= 1'b1;
                  state    <= ST_READ;
               end
            end
            ST_EMIT: begin
               // The read for the next neuron is held back until the event is accepted.
               if (spike_ready) begin
                  spike_valid <= 1'b0;
                  run_cnt     <= run_cnt + (AW+1)'(1);
                  if (last) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     idx      <= idx + AW'(1);
                     cur_addr <= idx + AW'(1);
                     cur_rd   <= 1'b1;
                     state    <= ST_READ;
                  end
               end
            end
            ST_DONE: begin
               spike_count <= run_cnt;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Randomized and directed bench for lif_array_scheduler against a timestep-level LIF model.
module tb_lif_array_scheduler;

   localparam int N  = 4;
   localparam int TH = 100;
   localparam int LK = 1;
   localparam int RF = 2;
   localparam int AW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic          tick;
   logic          busy, done, overrun, cur_rd;
   logic [AW-1:0] cur_addr;
   logic [7:0]    cur_data;
   logic          spike_valid;
   logic [AW-1:0] spike_addr;
   logic          spike_ready;
   logic [AW:0]   spike_count;

   lif_array_scheduler #(
      .NUM_NEURONS   (N),
      .THRESHOLD     (8'(TH)),
      .LEAK_RATE     (8'(LK)),
      .REFRAC_PERIOD (RF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .cur_rd      (cur_rd),
      .cur_addr    (cur_addr),
      .cur_data    (cur_data),
      .spike_valid (spike_valid),
      .spike_addr  (spike_addr),
      .spike_ready (spike_ready),
      .spike_count (spike_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // timestep-level reference: potentials, refractory counts, buffer contents
   int cur_mem [N];
   int mv [N];
   int mr [N];
   int exp_q [$];
   int obs_q [$];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mr[i] = 0;
      end
   endtask

   task automatic model_step();
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         if (mr[i] > 0) begin
            mr[i] = mr[i] - 1;
         end else if (mv[i] >= TH) begin
            exp_q.push_back(i);
            mv[i] = 0;
            mr[i] = RF;
         end else if (mv[i] < LK) begin
            mv[i] = cur_mem[i];
         end else if (mv[i] + cur_mem[i] - LK > 255) begin
            mv[i] = TH;
         end else begin
            mv[i] = mv[i] + cur_mem[i] - LK;
         end
      end
   endtask

   // current buffer: data valid one cycle after the read strobe, junk otherwise
   always @(posedge clk) begin
      logic          rd_s;
      logic [AW-1:0] a_s;
      rd_s = cur_rd;
      a_s  = cur_addr;
      #1;
      cur_data = rd_s ? 8'(cur_mem[a_s]) : 8'($urandom);
   end

   int            rd_next = 0;
   int            ovr_cnt = 0;
   int            done_cnt = 0;
   logic          pv_valid = 1'b0;
   logic          pv_ready = 1'b0;
   logic [AW-1:0] pv_addr = '0;

   always @(negedge clk) begin
      if (reset) begin
         rd_next  = 0;
         pv_valid = 1'b0;
      end else begin
         if (pv_valid && !pv_ready) begin
            check_eq("hold_valid", spike_valid, 1);
            check_eq("hold_addr", spike_addr, pv_addr);
         end
         if (spike_valid) check_eq("no_rd_in_emit", cur_rd, 0);
         if (cur_rd) begin
            check_eq("rd_addr", cur_addr, rd_next);
            rd_next = (rd_next + 1) % N;
         end
         if (spike_valid && spike_ready) obs_q.push_back(int'(spike_addr));
         if (overrun) ovr_cnt++;
         if (done) done_cnt++;
         pv_valid = spike_valid;
         pv_ready = spike_ready;
         pv_addr  = spike_addr;
      end
   end

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_overrun"}, overrun, 0);
      check_eq({tag, "_cur_rd"}, cur_rd, 0);
      check_eq({tag, "_cur_addr"}, cur_addr, 0);
      check_eq({tag, "_spike_valid"}, spike_valid, 0);
      check_eq({tag, "_spike_addr"}, spike_addr, 0);
      check_eq({tag, "_spike_count"}, spike_count, 0);
   endtask

   task automatic hard_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      tick = 1'b0;
      spike_ready = 1'b0;
      @(negedge clk);
      check_idle_zero("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // mode 0: ready high; 1: random ready; 2: each event stalled 5 cycles
   task automatic run_sweep(input int mode, input int ovr_at);
      int lat, n, stall, base;
      model_step();
      obs_q.delete();
      ovr_cnt = 0;
      done_cnt = 0;
      stall = 0;
      lat = -1;
      n = 0;
      @(posedge clk); #1;
      tick = 1'b1;
      spike_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      while (n < 400 && lat < 0) begin
         @(posedge clk); #1;
         n++;
         tick = (n == ovr_at);
         if (mode == 0) spike_ready = 1'b1;
         else if (mode == 1) spike_ready = ($urandom_range(0, 2) != 0);
         else spike_ready = (stall >= 5);
         @(negedge clk);
         if (n == 1) check_eq("busy_start", busy, 1);
         if (spike_valid && !spike_ready) stall++;
         if (spike_valid && spike_ready) stall = 0;
         if (done) lat = n;
      end
      if (lat < 0) check_eq("done_timeout", 0, 1);
      @(posedge clk); #1;
      tick = 1'b0;
      @(negedge clk);
      check_eq("busy_end", busy, 0);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("overrun_pulses", ovr_cnt, (ovr_at > 0) ? 1 : 0);
      check_eq("spike_count", spike_count, exp_q.size());
      check_eq("spike_n", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq("spike_addr", obs_q[i], exp_q[i]);
      base = 1 + 2 * N;
      if (mode == 0) check_eq("latency", lat, base + exp_q.size());
      else if (mode == 2) check_eq("latency_stall", lat, base + 6 * exp_q.size());
      else check_eq("latency_min", (lat >= base + exp_q.size()), 1);
   endtask

   task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
      cur_mem[0] = c0;
      cur_mem[1] = c1;
      cur_mem[2] = c2;
      cur_mem[3] = c3;
   endtask

   initial begin
      int got;
      reset = 1'b1;
      tick = 1'b0;
      spike_ready = 1'b0;
      cur_data = '0;
      set_cur(0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_zero("por");
      @(posedge clk); #1;
      reset = 1'b0;

      // overrun: second tick 3 cycles into a quiet sweep
      hard_reset();
      set_cur(0, 0, 0, 0);
      run_sweep(0, 3);

      // integrate and fire on neuron 0
      hard_reset();
      set_cur(60, 0, 0, 0);
      repeat (6) run_sweep(0, 0);

      // saturation: 99 + 200 - 1 clips to the threshold
      hard_reset();
      set_cur(0, 99, 0, 0);
      run_sweep(0, 0);
      cur_mem[1] = 200;
      run_sweep(0, 0);
      run_sweep(0, 0);
      cur_mem[1] = 0;
      run_sweep(0, 0);

      // backpressure: neurons 0 and 2 fire together with stalled ready
      hard_reset();
      set_cur(150, 0, 150, 0);
      run_sweep(0, 0);
      run_sweep(2, 0);

      // reset while an event is pending
      hard_reset();
      set_cur(255, 0, 50, 0);
      run_sweep(0, 0);
      cur_mem[1] = 255;
      run_sweep(0, 0);
      @(posedge clk); #1;
      tick = 1'b1;
      spike_ready = 1'b0;
      @(posedge clk); #1;
      tick = 1'b0;
      got = 0;
      for (int k = 0; k < 60 && got == 0; k++) begin
         @(negedge clk);
         if (spike_valid) got = 1;
      end
      check_eq("emit_reached", got, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_idle_zero("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      spike_ready = 1'b1;
      model_reset();
      set_cur(60, 60, 60, 60);
      repeat (4) run_sweep(0, 0);

      // randomized sweeps
      hard_reset();
      for (int s = 0; s < 40; s++) begin
         for (int i = 0; i < N; i++)
            cur_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 70);
         run_sweep($urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lif_array_scheduler.md
# lif_array_scheduler

Time-multiplexed controller that runs a single leaky-integrate-fire update datapath across `NUM_NEURONS` virtual neurons, holding each neuron's membrane potential and refractory count in local register arrays. On each timestep `tick` it sweeps neuron indices 0..N-1 in order. For each neuron it reads that neuron's input current from an external current buffer, applies the LIF update, and emits spiking neuron indices as address-events on a valid/ready stream. It sits between the synaptic current accumulator and the spike router.

## Interface
- `NUM_NEURONS`, 16: number of virtual neurons; range 2..256.
- `THRESHOLD`, 8'd255: firing threshold.
- `LEAK_RATE`, 8'd1: leak subtracted per timestep.
- `REFRAC_PERIOD`, 32: refractory length in timesteps; range 1..63.
- `AW`, $clog2(NUM_NEURONS): neuron address width (derived).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `tick`, in, 1: start-of-timestep pulse.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse at end of sweep.
- `overrun`, out, 1: one-cycle pulse when `tick` arrives while busy.
- `cur_rd`, out, 1: current-buffer read strobe.
- `cur_addr`, out, AW: neuron index being read.
- `cur_data`, in, 8: current value, valid exactly one cycle after `cur_rd`.
- `spike_valid`, out, 1: address-event valid.
- `spike_addr`, out, AW: index of the spiking neuron.
- `spike_ready`, in, 1: downstream accepts the event.
- `spike_count`, out, AW+1: spikes emitted in the last completed sweep.

## Operation
- State per neuron: `V[i]` (8 bit) and `R[i]` (6 bit). Reset clears both to 0.
- FSM states: IDLE, READ, UPDATE, EMIT, DONE.
- **IDLE**
  - `tick`=1 → idx=0, running count=0, go to READ.
- **READ**
  - Drive `cur_rd`=1 and `cur_addr`=idx.
  - Go to UPDATE.
  - Current is read even for refractory neurons; the value is then discarded.
- **UPDATE**: sample `cur_data`=I. Evaluate in priority order:
  1. R[i]≠0 → R[i]−1; V unchanged; no spike.
  2. V[i]≥THRESHOLD → V[i]=0, R[i]=REFRAC_PERIOD, spike.
  3. V[i]<LEAK_RATE → V[i]=I.
  4. Otherwise, compute the 9-bit sum S=V+I−LEAK_RATE. If S>255, V[i]=THRESHOLD; else V[i]=S[7:0].
- **Transitions out of UPDATE**
  - Spike → EMIT.
  - Else, idx=N−1 → DONE.
  - Else idx+1 → READ.
- **EMIT**
  - Hold `spike_valid`=1 and `spike_addr`=idx stable until `spike_ready`.
  - On handshake: increment the running count, then idx+1 → READ, or DONE if idx=N−1.
- **DONE**
  - `done`=1 for one cycle.
  - Latch the running count into `spike_count`.
  - Go to IDLE.
- **Threshold rule**: a neuron whose V reached threshold spikes on the *next* timestep, not the one in which it crossed.
- **tick while busy**: ignored, and `overrun` pulses. A `tick` in the DONE cycle also counts as overrun.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `overrun`=0, `cur_rd`=0, `cur_addr`=0, `spike_valid`=0, `spike_addr`=0, `spike_count`=0.
- Sweep latency with no spikes and no stalls:
  - `tick` sampled in cycle t.
  - `cur_rd` for neuron k is asserted in cycle t+1+2k.
  - `done` is asserted in cycle t+1+2N.
- Each spike adds ≥1 EMIT cycle, plus any cycles with `spike_ready` low.
- `busy`=1 from cycle t+1 through the DONE cycle inclusive.
- `spike_valid` never drops without a handshake; no new `cur_rd` is issued while in EMIT.
- Reset mid-sweep aborts the sweep immediately:
  - Any pending event is dropped.
  - All V/R state clears.
  - `spike_count` returns to 0.

## Structure
- Package `lif_pkg` holds:
  - the state enum `lif_sched_state_t`;
  - localparams for potential width (8) and refractory width (6).
- Sub-module `lif_update_core`: combinational; inputs V, R, I and the parameters; outputs V', R', spike. Reusable by the standalone neuron.
- V and R arrays are flops indexed by idx; no RAM inference is required.

## Test plan
- **Integrate and fire.** N=4, THRESHOLD=100, LEAK=1, REFRAC=2, I[0]=60 every tick.
  - V[0] is 60, then 119.
  - Spike on addr 0 at timestep 3.
  - Timesteps 4 and 5: no spike, V stays 0.
  - Timestep 6: V=60.
- **Saturation.** THRESHOLD=255, I[1]=200 on two ticks.
  - V[1] is 200, then 255 (399 clipped).
  - Spike on addr 1 at timestep 3.
- **Backpressure.** Neurons 0 and 2 both spike; `spike_ready` held low for 5 cycles.
  - `spike_valid`/`spike_addr`=0 stay stable.
  - No `cur_rd` is issued during the stall.
  - Both events arrive in order 0, 2, and `spike_count`=2.
- **Overrun.** Second `tick` 3 cycles after the first, N=4.
  - `overrun` pulses once; the sweep is unaffected.
  - `done` arrives at t+9.
- **Reset mid-sweep.** Assert `reset` while in EMIT.
  - All outputs go to 0 and all V/R clear.
  - The next tick with I=60 gives V=60 and no spike.
